pool_ctrl: RTL

POOL_CTRL -- requirements
Module: pool_ctrl

---
 rtl/pool_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pool_ctrl.sv
// 2x2 max-pool sequencer: reads four signed activations per output from GB, writes the
// maximum to BF and emits a 16-bit nonzero-flag word per group of sixteen outputs.
module pool_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WIDTH  = 12
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         cfg_val,
    output logic                         cfg_rdy,
    input  logic [ADDR_WIDTH-1:0]        cfg_gb_base,
    input  logic [ADDR_WIDTH-1:0]        cfg_bf_base,
    input  logic [NUM_WIDTH-1:0]         cfg_num_out,
    output logic                         POOLGB_rdy,
    output logic [ADDR_WIDTH-1:0]        POOLGB_addr,
    input  logic                         GBPOOL_val,
    input  logic signed [DATA_WIDTH-1:0] GBPOOL_data,
    output logic                         BF_val,
    input  logic                         BF_rdy,
    output logic [ADDR_WIDTH-1:0]        BF_addr,
    output logic signed [DATA_WIDTH-1:0] BF_data,
    output logic                         BF_flg_val,
    input  logic                         BF_flg_rdy,
    output logic [NUM_WIDTH-5:0]         BF_flg_addr,
    output logic [15:0]                  BF_flg_data,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StFlg, StDone} state_e;

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          gb_base_q, gb_base_d;
    logic [ADDR_WIDTH-1:0]          bf_base_q, bf_base_d;
    logic [NUM_WIDTH-1:0]           num_out_q, num_out_d;
    logic [NUM_WIDTH-1:0]           out_idx_q, out_idx_d;
    logic [1:0]                     k_q, k_d;
    logic signed [DATA_WIDTH-1:0]   max_q, max_d;
    logic [15:0]                    flag_q, flag_d;
    logic [NUM_WIDTH-5:0]           flg_addr_q, flg_addr_d;
    logic                           last_q, last_d;

    always_comb begin
        state_d    = state_q;
        gb_base_d  = gb_base_q;
        bf_base_d  = bf_base_q;
        num_out_d  = num_out_q;
        out_idx_d  = out_idx_q;
        k_d        = k_q;
        max_d      = max_q;
        flag_d     = flag_q;
        flg_addr_d = flg_addr_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_val) begin
                    gb_base_d = cfg_gb_base;
                    bf_base_d = cfg_bf_base;
                    num_out_d = cfg_num_out;
                    out_idx_d = '0;
                    k_d       = '0;
                    last_d    = 1'b0;
                    state_d   = (cfg_num_out == '0) ? StDone : StRd;
                end
            end
            StRd: begin
                if (GBPOOL_val) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd0 || GBPOOL_data > max_q) begin
                        max_d = GBPOOL_data;
                    end
                    if (k_q == 2'd3) begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                if (BF_rdy) begin
                    flag_d[out_idx_q[3:0]] = (max_q != '0);
                    out_idx_d  = out_idx_q + NUM_WIDTH'(1);
                    // Remember the group just written; out_idx has moved on by the flag write.
                    flg_addr_d = out_idx_q[NUM_WIDTH-1:4];
                    last_d     = (out_idx_q == num_out_q - NUM_WIDTH'(1));
                    if (out_idx_q[3:0] == 4'hF || out_idx_q == num_out_q - NUM_WIDTH'(1)) begin
                        state_d = StFlg;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StFlg: begin
                if (BF_flg_rdy) begin
                    flag_d  = '0;
                    state_d = last_q ? StDone : StRd;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            gb_base_q  <= '0;
            bf_base_q  <= '0;
            num_out_q  <= '0;
            out_idx_q  <= '0;
            k_q        <= '0;
            max_q      <= '0;
            flag_q     <= '0;
            flg_addr_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gb_base_q  <= gb_base_d;
            bf_base_q  <= bf_base_d;
            num_out_q  <= num_out_d;
            out_idx_q  <= out_idx_d;
            k_q        <= k_d;
            max_q      <= max_d;
            flag_q     <= flag_d;
            flg_addr_q <= flg_addr_d;
            last_q     <= last_d;
        end
    end

    // {out_idx, k} is exactly 4*out_idx + k.
    assign POOLGB_addr = gb_base_q + ADDR_WIDTH'({out_idx_q, k_q});
    assign BF_addr     = bf_base_q + ADDR_WIDTH'(out_idx_q);
    assign BF_data     = max_q;
    assign BF_flg_addr = flg_addr_q;
    assign BF_flg_data = flag_q;
    assign cfg_rdy     = (state_q == StIdle);
    assign POOLGB_rdy  = (state_q == StRd);
    assign BF_val      = (state_q == StWr);
    assign BF_flg_val  = (state_q == StFlg);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule
